audio_cts_measure: RTL

- Measures the Cycle Time Stamp (CTS) for the audio clock regeneration packet.
- Counts clk_pixel cycles across one window of N/128 audio sample ticks.
- Publishes each measured CTS over a valid/ready handshake to the packet picker, which places it in the audio clock regeneration packet.
- Sits directly upstream of that packet. Its input is a single-cycle sample tick already synchronized into clk_pixel.

---
 rtl/audio_cts_measure_if.sv | 24 ++
 rtl/audio_cts_measure.sv | 138 +++++++++++++
 2 files changed

// File: rtl/audio_cts_measure_if.sv
// Handshake bundle that carries a measured CTS from the CTS measurement block
// to the packet picker, plus the overwrite indication.
interface audio_cts_measure_if #(
    parameter int CTS_WIDTH = 20
);
    logic [CTS_WIDTH-1:0] cts;
    logic                 cts_valid;
    logic                 cts_ready;
    logic                 cts_overrun;

    modport master (
        output cts,
        output cts_valid,
        output cts_overrun,
        input  cts_ready
    );

    modport slave (
        input  cts,
        input  cts_valid,
        input  cts_overrun,
        output cts_ready
    );
endinterface

// File: rtl/audio_cts_measure.sv
// Audio clock regeneration CTS measurement: counts clk_pixel cycles across a
// window of N/128 audio sample ticks and publishes the count over a
// valid/ready handshake. Windows are back to back; a window that runs past
// CTS_TIMEOUT cycles declares audio lost and waits for a fresh boundary tick.
module audio_cts_measure #(
    parameter int N           = 6144,
    parameter int CTS_IDEAL   = 25200,
    parameter int CTS_TIMEOUT = 50400,
    parameter int CTS_WIDTH   = 20
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 audio_sample_tick,
    audio_cts_measure_if.master  cts_bus,
    output logic                 audio_lost,
    output logic [19:0]          n
);

    localparam int TICKS  = N / 128;
    localparam int TICK_W = $clog2(TICKS + 1);

    localparam logic [TICK_W-1:0]    LAST_TICK = TICK_W'(TICKS - 1);
    localparam logic [CTS_WIDTH-1:0] TIMEOUT_C = CTS_WIDTH'(CTS_TIMEOUT);

    if ((N % 128) != 0 || N < 128) begin : g_bad_n
        $error("N must be a non-zero multiple of 128");
    end
    if (64'(CTS_TIMEOUT) >= (64'(1) << CTS_WIDTH)) begin : g_bad_timeout
        $error("CTS_TIMEOUT does not fit in CTS_WIDTH bits");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CTS_WIDTH-1:0]  cycle_cnt;
    logic [TICK_W-1:0]     tick_cnt;
    logic                  window_end;
    logic                  timeout;
    logic                  restart;
    logic [CTS_WIDTH-1:0]  cts_r;
    logic                  cts_valid_r;
    logic                  cts_overrun_r;

    // The cycle counter never wraps: it parks at the timeout value.
    function automatic logic [CTS_WIDTH-1:0] sat_inc(input logic [CTS_WIDTH-1:0] v);
        if (v >= TIMEOUT_C) begin
            return v;
        end
        return v + CTS_WIDTH'(1);
    endfunction

    // State register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a tick on the timeout cycle starts a new window straight away.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (audio_sample_tick) state_next = MEASURE;
            MEASURE: if (timeout && !audio_sample_tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Window boundary, timeout and counter-restart decodes.
    always_comb begin
        window_end = 1'b0;
        timeout    = 1'b0;
        restart    = 1'b0;
        case (state)
            IDLE: restart = audio_sample_tick;
            MEASURE: begin
                window_end = audio_sample_tick && (tick_cnt == LAST_TICK);
                timeout    = !window_end && (cycle_cnt == TIMEOUT_C);
                restart    = window_end || (timeout && audio_sample_tick);
            end
            default: ;
        endcase
    end

    // Counters: a boundary cycle counts as cycle 0 of the new window, so the
    // count seen on the closing boundary is exactly t1 - t0.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            tick_cnt  <= '0;
        end else if (restart) begin
            cycle_cnt <= CTS_WIDTH'(1);
            tick_cnt  <= '0;
        end else if (state == MEASURE) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (audio_sample_tick) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    // Publish / handshake / audio-lost register; a publish wins over acceptance.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cts_r         <= CTS_WIDTH'(CTS_IDEAL);
            cts_valid_r   <= 1'b0;
            cts_overrun_r <= 1'b0;
            audio_lost    <= 1'b1;
        end else begin
            cts_overrun_r <= 1'b0;
            if (window_end) begin
                cts_r         <= cycle_cnt;
                cts_valid_r   <= 1'b1;
                cts_overrun_r <= cts_valid_r && !cts_bus.cts_ready;
                audio_lost    <= 1'b0;
            end else begin
                if (cts_valid_r && cts_bus.cts_ready) begin
                    cts_valid_r <= 1'b0;
                end
                if (timeout) begin
                    audio_lost <= 1'b1;
                end
            end
        end
    end

    assign cts_bus.cts         = cts_r;
    assign cts_bus.cts_valid   = cts_valid_r;
    assign cts_bus.cts_overrun = cts_overrun_r;
    assign n                   = 20'(N);

endmodule
